// File: rtl/lvg_mm_seq.sv
// rtl/lvg_mm_seq.sv - fixed-point DIM x DIM matrix unit computing B = act(L x R + A)
//
// Purpose:
//   Sequential matrix multiply-accumulate. One k-step of the outer-product sum
//   is applied to all DIM*DIM accumulators per cycle. The result is rounded
//   toward -inf back to Q(W-FRAC).FRAC, saturated, and optionally ReLU'd.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any compute in flight)
//   instr        8-bit opcode, sampled when instr_valid=1
//   instr_valid  qualifies instr
//   l_flat       L operand, element (i,j) at [(i*DIM+j)*W +: W]
//   r_flat       R operand, same packing
//   a_flat       A addend, same packing
//   b_flat       result register, same packing
//   busy         high while a compute is in progress (MAC or WB)
//   done         one-cycle pulse after b_flat is written by a compute
//   err          one-cycle pulse after a rejected or illegal instruction

module lvg_mm_seq #(
  parameter int DIM  = 4,
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            instr,
  input  logic                  instr_valid,
  input  logic [DIM*DIM*W-1:0]  l_flat,
  input  logic [DIM*DIM*W-1:0]  r_flat,
  input  logic [DIM*DIM*W-1:0]  a_flat,
  output logic [DIM*DIM*W-1:0]  b_flat,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Accumulator is wide enough that DIM full-scale products plus the shifted
  // addend can never overflow.
  localparam int AW = 2 * W + $clog2(DIM) + 1;
  localparam int KW = $clog2(DIM);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [7:0] OP_NOP     = 8'd0;
  localparam logic [7:0] OP_LOAD_L  = 8'd1;
  localparam logic [7:0] OP_LOAD_RA = 8'd2;
  localparam logic [7:0] OP_MM      = 8'd3;
  localparam logic [7:0] OP_MM_RELU = 8'd4;
  localparam logic [7:0] OP_CLEAR   = 8'd5;

  logic [1:0]              state_q;
  logic [KW-1:0]           k_q;
  logic                    relu_q;
  logic signed [W-1:0]     l_m [DIM][DIM];
  logic signed [W-1:0]     r_m [DIM][DIM];
  logic signed [W-1:0]     a_m [DIM][DIM];
  logic signed [AW-1:0]    acc [DIM][DIM];

  assign busy = (state_q != S_IDLE);

  // Full signed product sign-extended to accumulator width. The operands are
  // sign-extended to 2W first so the low 2W bits of the product are exact.
  function automatic logic signed [AW-1:0] mul_ext(input logic signed [W-1:0] x,
                                                   input logic signed [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
    return {{(AW-2*W){p[2*W-1]}}, p};
  endfunction

  // Add the addend aligned to the product scale, drop FRAC bits with an
  // arithmetic shift (floor), clamp to W bits, then apply the optional ReLU.
  function automatic logic [W-1:0] wb_elem(input logic signed [AW-1:0] acc_v,
                                           input logic signed [W-1:0]  a_v,
                                           input logic                 relu_v);
    logic signed [AW-1:0] a_ext;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shr;
    logic [W-1:0]         res;
    a_ext = {{(AW-W){a_v[W-1]}}, a_v};
    sum   = acc_v + (a_ext <<< FRAC);
    shr   = sum >>> FRAC;
    if (shr > SAT_MAX)      res = SAT_MAX[W-1:0];
    else if (shr < SAT_MIN) res = SAT_MIN[W-1:0];
    else                    res = shr[W-1:0];
    if (relu_v && res[W-1]) res = '0;
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      relu_q  <= 1'b0;
      b_flat  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          l_m[i][j] <= '0;
          r_m[i][j] <= '0;
          a_m[i][j] <= '0;
          acc[i][j] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      // Illegal opcodes always flag; any non-NOP while busy is dropped and flagged.
      err  <= instr_valid && ((instr > OP_CLEAR) ||
                              ((instr != OP_NOP) && (state_q != S_IDLE)));

      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            case (instr)
              OP_LOAD_L: begin
                for (int i = 0; i < DIM; i++)
                  for (int j = 0; j < DIM; j++)
                    l_m[i][j] <= l_flat[(i*DIM+j)*W +: W];
              end
              OP_LOAD_RA: begin
                for (int i = 0; i < DIM; i++) begin
                  for (int j = 0; j < DIM; j++) begin
                    r_m[i][j] <= r_flat[(i*DIM+j)*W +: W];
                    a_m[i][j] <= a_flat[(i*DIM+j)*W +: W];
                  end
                end
              end
              OP_MM, OP_MM_RELU: begin
                for (int i = 0; i < DIM; i++)
                  for (int j = 0; j < DIM; j++)
                    acc[i][j] <= '0;
                k_q     <= '0;
                relu_q  <= (instr == OP_MM_RELU);
                state_q <= S_MAC;
              end
              OP_CLEAR: begin
                b_flat <= '0;
                for (int i = 0; i < DIM; i++) begin
                  for (int j = 0; j < DIM; j++) begin
                    l_m[i][j] <= '0;
                    r_m[i][j] <= '0;
                    a_m[i][j] <= '0;
                  end
                end
              end
              default: ;
            endcase
          end
        end

        S_MAC: begin
          for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
              acc[i][j] <= acc[i][j] + mul_ext(l_m[i][k_q], r_m[k_q][j]);
          if (k_q == KW'(DIM - 1)) begin
            k_q     <= '0;
            state_q <= S_WB;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end

        S_WB: begin
          for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
              b_flat[(i*DIM+j)*W +: W] <= wb_elem(acc[i][j], a_m[i][j], relu_q);
          done    <= 1'b1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lvg_mm_seq.sv
// tb/tb_lvg_mm_seq.sv - self-checking bench for lvg_mm_seq (DIM=4/W=16/FRAC=8 and DIM=2/W=8/FRAC=4)

module tb_lvg_mm_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]   instr1;
  logic         iv1;
  logic [255:0] l1, r1, a1, b1;
  logic         busy1, done1, err1;

  logic [7:0]   instr2;
  logic         iv2;
  logic [31:0]  l2, r2, a2, b2;
  logic         busy2, done2, err2;

  lvg_mm_seq #(.DIM(4), .W(16), .FRAC(8)) u_dut4 (
    .clk(clk), .rst(rst), .instr(instr1), .instr_valid(iv1),
    .l_flat(l1), .r_flat(r1), .a_flat(a1), .b_flat(b1),
    .busy(busy1), .done(done1), .err(err1)
  );

  lvg_mm_seq #(.DIM(2), .W(8), .FRAC(4)) u_dut2 (
    .clk(clk), .rst(rst), .instr(instr2), .instr_valid(iv2),
    .l_flat(l2), .r_flat(r2), .a_flat(a2), .b_flat(b2),
    .busy(busy2), .done(done2), .err(err2)
  );

  int total = 0;
  int bad   = 0;
  int lm [4][4];
  int rm [4][4];
  int am [4][4];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int dimf(int sel);  return (sel == 1) ? 4 : 2;  endfunction
  function automatic int wf(int sel);    return (sel == 1) ? 16 : 8; endfunction
  function automatic int fracf(int sel); return (sel == 1) ? 8 : 4;  endfunction

  function automatic void zero_ops();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        lm[i][j] = 0; rm[i][j] = 0; am[i][j] = 0;
      end
  endfunction

  // which: 0 = L, 1 = R, 2 = A
  function automatic logic [255:0] pack(int sel, int which);
    logic [255:0] f;
    int d, w, v;
    f = '0; d = dimf(sel); w = wf(sel);
    for (int i = 0; i < d; i++)
      for (int j = 0; j < d; j++) begin
        v = (which == 0) ? lm[i][j] : (which == 1) ? rm[i][j] : am[i][j];
        for (int b = 0; b < w; b++) f[(i*d+j)*w+b] = v[b];
      end
    return f;
  endfunction

  // Reference: exact integer sum, floor division by 2^FRAC, clamp, ReLU.
  function automatic logic [255:0] model(int sel, bit relu);
    logic [255:0] f;
    int d, w, fr;
    longint one, hi, lo, s, v;
    f = '0; d = dimf(sel); w = wf(sel); fr = fracf(sel);
    one = longint'(1) << fr;
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -(longint'(1) << (w - 1));
    for (int i = 0; i < d; i++)
      for (int j = 0; j < d; j++) begin
        s = 0;
        for (int k = 0; k < d; k++) s += longint'(lm[i][k]) * longint'(rm[k][j]);
        s += longint'(am[i][j]) * one;
        v = s / one;
        if ((s % one) != 0 && s < 0) v -= 1;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        if (relu && v < 0) v = 0;
        for (int b = 0; b < w; b++) f[(i*d+j)*w+b] = v[b];
      end
    return f;
  endfunction

  function automatic int rnd(int mag);
    return int'($urandom_range(0, 2 * mag - 1)) - mag;
  endfunction

  function automatic logic busy_of(int sel); return (sel == 1) ? busy1 : busy2; endfunction
  function automatic logic done_of(int sel); return (sel == 1) ? done1 : done2; endfunction

  task automatic set_ops(int sel);
    logic [255:0] t;
    if (sel == 1) begin
      l1 = pack(1, 0); r1 = pack(1, 1); a1 = pack(1, 2);
    end else begin
      t = pack(2, 0); l2 = t[31:0];
      t = pack(2, 1); r2 = t[31:0];
      t = pack(2, 2); a2 = t[31:0];
    end
  endtask

  task automatic drive(int sel, logic [7:0] op);
    if (sel == 1) begin instr1 = op; iv1 = 1'b1; end
    else          begin instr2 = op; iv2 = 1'b1; end
  endtask

  task automatic undrive(int sel);
    if (sel == 1) iv1 = 1'b0; else iv2 = 1'b0;
  endtask

  function automatic logic [255:0] res_of(int sel);
    logic [255:0] t;
    t = '0;
    if (sel == 1) t = b1; else t[31:0] = b2;
    return t;
  endfunction

  task automatic run_mm(int sel, logic [7:0] op, bit do_load, string tag);
    int c, nb, d;
    bit seen;
    d = dimf(sel);
    set_ops(sel);
    if (do_load) begin
      @(negedge clk); drive(sel, 8'd1);
      @(negedge clk); drive(sel, 8'd2);
    end
    @(negedge clk); drive(sel, op);
    nb = 0; seen = 1'b0; c = 0;
    while (!seen && c < 40) begin
      @(negedge clk); c++; undrive(sel);
      if (busy_of(sel)) nb++;
      if (done_of(sel)) seen = 1'b1;
    end
    chk({tag, "_seen"}, 256'(seen), 256'(1));
    chk({tag, "_lat"}, 256'(c), 256'(d + 2));
    chk({tag, "_busy"}, 256'(nb), 256'(d + 1));
    chk({tag, "_res"}, res_of(sel), model(sel, op == 8'd4));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [255:0] e, prev, newl;
    bit seen;
    int p, sel, mag;

    rst = 1'b1;
    instr1 = '0; iv1 = 1'b0; l1 = '0; r1 = '0; a1 = '0;
    instr2 = '0; iv2 = 1'b0; l2 = '0; r2 = '0; a2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_b", b1, '0);
    chk("rst_flags", 256'({busy1, done1, err1}), '0);
    rst = 1'b0;

    // Identity pass-through
    zero_ops();
    for (int i = 0; i < 4; i++) begin
      lm[i][i] = 'h100;
      for (int j = 0; j < 4; j++) rm[i][j] = 'h10 * (i * 4 + j + 1);
    end
    run_mm(1, 8'd3, 1'b1, "ident");
    chk("ident_eq_r", b1, pack(1, 1));

    // Addend and fraction
    zero_ops();
    for (int i = 0; i < 4; i++) begin
      lm[i][i] = 'h200; rm[i][i] = 'h80;
      for (int j = 0; j < 4; j++) am[i][j] = 'h80;
    end
    run_mm(1, 8'd3, 1'b1, "addend");
    e = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) e[(i*4+j)*16 +: 16] = (i == j) ? 16'h0180 : 16'h0080;
    chk("addend_const", b1, e);

    // Positive saturation
    zero_ops();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin lm[i][j] = 'h7FFF; rm[i][j] = 'h7FFF; end
    run_mm(1, 8'd3, 1'b1, "satp");
    chk("satp_const", b1, {16{16'h7FFF}});

    // Most negative value
    zero_ops();
    for (int i = 0; i < 4; i++) begin
      rm[i][i] = 'h100;
      for (int j = 0; j < 4; j++) lm[i][j] = -32768;
    end
    run_mm(1, 8'd3, 1'b1, "satn");
    chk("satn_const", b1, {16{16'h8000}});

    // Negative values with and without ReLU
    zero_ops();
    for (int i = 0; i < 4; i++) begin
      lm[i][i] = 'h100;
      for (int j = 0; j < 4; j++) rm[i][j] = -256;
    end
    run_mm(1, 8'd3, 1'b1, "neg");
    chk("neg_const", b1, {16{16'hFF00}});
    run_mm(1, 8'd4, 1'b0, "relu");
    chk("relu_const", b1, '0);

    // Busy rejection and back-to-back acceptance in the done cycle
    zero_ops();
    for (int i = 0; i < 4; i++) begin
      lm[i][i] = 'h100;
      for (int j = 0; j < 4; j++) begin rm[i][j] = rnd(4096); am[i][j] = rnd(64); end
    end
    set_ops(1);
    @(negedge clk); drive(1, 8'd1);
    @(negedge clk); drive(1, 8'd2);
    @(negedge clk); drive(1, 8'd3);
    @(negedge clk);
    newl = '0;
    for (int i = 0; i < 4; i++) newl[(i*4+i)*16 +: 16] = 16'h0200;
    l1 = newl; drive(1, 8'd1);
    @(negedge clk); undrive(1);
    chk("rej_err", 256'(err1), 256'(1));
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (done1) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rej_seen", 256'(seen), 256'(1));
    chk("rej_res", b1, model(1, 1'b0));
    drive(1, 8'd3);
    @(negedge clk); undrive(1);
    chk("b2b_busy", 256'(busy1), 256'(1));
    chk("b2b_err", 256'(err1), 256'(0));
    p = 1;
    while (!done1 && p < 20) begin @(negedge clk); p++; end
    chk("b2b_period", 256'(p), 256'(6));
    chk("b2b_res", b1, model(1, 1'b0));
    l1 = pack(1, 0);

    // Illegal opcode in IDLE, then NOP
    prev = b1;
    drive(1, 8'h09);
    @(negedge clk); undrive(1);
    chk("ill_err", 256'(err1), 256'(1));
    chk("ill_busy", 256'(busy1), 256'(0));
    chk("ill_b", b1, prev);
    @(negedge clk);
    chk("ill_pulse", 256'(err1), 256'(0));
    drive(1, 8'd0);
    @(negedge clk); undrive(1);
    chk("nop_err", 256'(err1), 256'(0));

    // Reset during MAC cycle 2
    drive(1, 8'd3);
    @(negedge clk); undrive(1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 256'(busy1), 256'(0));
    chk("mrst_b", b1, '0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (done1) seen = 1'b1; end
    chk("mrst_nodone", 256'(seen), 256'(0));

    // CLEAR after a compute with a nonzero addend
    zero_ops();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        lm[i][j] = rnd(512); rm[i][j] = rnd(512); am[i][j] = 64 + int'($urandom_range(0, 255));
      end
    run_mm(1, 8'd3, 1'b1, "preclr");
    @(negedge clk); drive(1, 8'd5);
    @(negedge clk); undrive(1);
    chk("clr_b", b1, '0);
    chk("clr_err", 256'(err1), 256'(0));
    zero_ops();
    run_mm(1, 8'd3, 1'b0, "postclr");

    // Identity at DIM=2, W=8, FRAC=4
    zero_ops();
    for (int i = 0; i < 2; i++) begin
      lm[i][i] = 'h10;
      for (int j = 0; j < 2; j++) rm[i][j] = 'h10 * (i * 2 + j + 1);
    end
    run_mm(2, 8'd3, 1'b1, "ident2");
    chk("ident2_eq_r", res_of(2), pack(2, 1));

    // Randomized computes on both configurations
    for (int n = 0; n < 24; n++) begin
      sel = (n % 4 == 3) ? 2 : 1;
      mag = (n % 2 == 1) ? (1 << (wf(sel) - 1)) : (1 << (fracf(sel) + 1));
      zero_ops();
      for (int i = 0; i < dimf(sel); i++)
        for (int j = 0; j < dimf(sel); j++) begin
          lm[i][j] = rnd(mag); rm[i][j] = rnd(mag); am[i][j] = rnd(mag);
        end
      run_mm(sel, 8'(3 + $urandom_range(0, 1)), 1'b1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
